// File: rtl/seq_shifter_if.sv
// rtl/seq_shifter_if.sv - start/busy/done handshake bundle between pipeline controller and shifter
interface seq_shifter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   shift_in;
  logic [SHAMT_W-1:0] shamt;
  logic               flush;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   shift_out;

  modport master (
    output start, op, shift_in, shamt, flush,
    input  busy, done, shift_out
  );

  modport slave (
    input  start, op, shift_in, shamt, flush,
    output busy, done, shift_out
  );
endinterface

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - bit-serial SLL/SRL/ROTR/SRA unit, one bit position per clock
module seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_shifter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_ROTR = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   shifted;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] count;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   out_q;

  always_comb begin
    shifted = work;
    case (op_q)
      OP_SLL:  shifted = {work[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, work[WIDTH-1:1]};
      OP_ROTR: shifted = {work[0], work[WIDTH-1:1]};
      OP_SRA:  shifted = {work[WIDTH-1], work[WIDTH-1:1]};
      default: shifted = work;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.shift_out = out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      op_q   <= OP_SLL;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      out_q  <= '0;
    end else if (bus.flush) begin
      // Cancel wins over everything, including a same-cycle start; result register is left alone.
      state  <= IDLE;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            work  <= bus.shift_in;
            op_q  <= bus.op;
            count <= bus.shamt;
            if (bus.shamt != '0) begin
              state  <= SHIFT;
              busy_q <= 1'b1;
            end else begin
              // Zero shift skips straight to the result, using the operand as-is.
              state  <= FINISH;
              done_q <= 1'b1;
              out_q  <= bus.shift_in;
            end
          end
        end
        SHIFT: begin
          work  <= shifted;
          count <= count - SHAMT_W'(1);
          if (count == SHAMT_W'(1)) begin
            state  <= FINISH;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            out_q  <= shifted;
          end
        end
        FINISH: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - directed scoreboard bench for seq_shifter
module tb_seq_shifter;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [31:0] exp_q[$];

  seq_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  seq_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
    logic [63:0] dd;
    dd = {d, d} >> s;
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return dd[31:0];
      default: return 32'($signed(d) >>> s);
    endcase
  endfunction

  task automatic watch_no_done(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      seen |= bus.done;
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  // Called at a falling edge; returns at a falling edge. repulse_at>0 re-pulses start mid-shift.
  task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                        input logic [31:0] exp, input int repulse_at, input string tag);
    int lat;
    int busy_cnt;
    logic [31:0] want;
    exp_q.push_back(exp);
    bus.start    = 1'b1;
    bus.op       = o;
    bus.shift_in = d;
    bus.shamt    = s;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!bus.done && lat < 70) begin
      busy_cnt += int'(bus.busy);
      if (lat == repulse_at) begin
        bus.start    = 1'b1;
        bus.op       = 2'b00;
        bus.shift_in = 32'h0000_0003;
        bus.shamt    = 5'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(s) + 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(s));
    chk({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    chk({tag, "_result"}, bus.shift_out, want);
    @(negedge clk);
    chk({tag, "_single_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_hold"}, bus.shift_out, want);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rd;
    logic [4:0]  rs;
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.shift_in = '0;
    bus.shamt    = '0;
    bus.flush    = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_out", bus.shift_out, 32'h0000_0000);
    watch_no_done("idle_no_done", 10);

    run_op(2'b11, 32'h8000_0010, 5'd4,  32'hF800_0001, 0, "sra4");
    run_op(2'b01, 32'h8000_0010, 5'd4,  32'h0800_0001, 0, "srl4");
    run_op(2'b10, 32'h1234_5678, 5'd0,  32'h1234_5678, 0, "rotr0");
    run_op(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 0, "sll31");
    run_op(2'b10, 32'h0000_00F1, 5'd4,  32'h1000_000F, 0, "rotr4");
    run_op(2'b01, 32'hFFFF_FFFF, 5'd8,  32'h00FF_FFFF, 3, "srl_repulse");
    watch_no_done("repulse_dropped", 5);

    // Flush on the third shift cycle: no completion, result register untouched.
    bus.start    = 1'b1;
    bus.op       = 2'b00;
    bus.shift_in = 32'h0000_0001;
    bus.shamt    = 5'd8;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_done", {31'd0, bus.done}, 32'd0);
    chk("flush_out", bus.shift_out, 32'h00FF_FFFF);
    run_op(2'b11, 32'h4000_0000, 5'd2, 32'h1000_0000, 0, "after_flush");

    // Flush and start together: start must be dropped.
    bus.start    = 1'b1;
    bus.flush    = 1'b1;
    bus.op       = 2'b01;
    bus.shift_in = 32'hDEAD_BEEF;
    bus.shamt    = 5'd3;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_start_busy", {31'd0, bus.busy}, 32'd0);
    watch_no_done("flush_start_no_done", 6);
    chk("flush_start_out", bus.shift_out, 32'h1000_0000);

    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      rd = $urandom;
      rs = 5'($urandom_range(0, 31));
      run_op(ro, rd, rs, model(ro, rd, rs), 0, "rand");
    end

    // Asynchronous reset between edges while shifting.
    run_op(2'b01, 32'hFFFF_FFFF, 5'd8, 32'h00FF_FFFF, 0, "pre_reset");
    bus.start    = 1'b1;
    bus.op       = 2'b11;
    bus.shift_in = 32'h8000_0000;
    bus.shamt    = 5'd20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", {31'd0, bus.busy}, 32'd0);
    chk("async_done", {31'd0, bus.done}, 32'd0);
    chk("async_out", bus.shift_out, 32'h0000_0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("post_reset_no_done", 30);
    chk("post_reset_out", bus.shift_out, 32'h0000_0000);
    run_op(2'b00, 32'h0000_00A5, 5'd4, 32'h0000_0A50, 0, "post_reset_op");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Multi-cycle shift unit for the MIPS execute stage. It performs SRL, SRA, ROTR and SLL by shifting one bit per clock.
- It handles the right-shift direction, including sign fill, that the combinational branch-offset left shifter never needs.
- It serves shift instructions when the ALU stalls for a multi-cycle op. Control uses a START/BUSY/DONE handshake with the pipeline controller.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, shift-amount width. It must satisfy 2**SHAMT_W == WIDTH.

Ports:
- CLK  input  1  system clock; rising edge active.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  request strobe; sampled only when BUSY=0.
- OP  input  2  operation: 00 SLL, 01 SRL, 10 ROTR, 11 SRA.
- SHIFT_IN  input  WIDTH  operand.
- SHAMT  input  SHAMT_W  shift amount, 0..WIDTH-1.
- FLUSH  input  1  synchronous cancel from the pipeline controller.
- BUSY  output  1  high from the cycle after START is accepted until DONE is asserted; new START is ignored while high.
- DONE  output  1  one-cycle pulse; SHIFT_OUT is valid in this cycle.
- SHIFT_OUT  output  WIDTH  result register; holds its value until the next DONE.

Behaviour:
- Reset (RESET_N=0, asynchronous): state=IDLE, BUSY=0, DONE=0, SHIFT_OUT=0, count=0, working reg=0.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - If START=1, latch SHIFT_IN into the working reg and latch OP; set count=SHAMT.
  - Next state is SHIFT if SHAMT!=0, else FINISH.
  - BUSY goes high the next cycle.
- SHIFT: on each edge, shift the working reg one bit per OP and decrement count. When count==1 on that edge, the next state is FINISH.
  - SLL: {reg[WIDTH-2:0],1'b0}.
  - SRL: {1'b0,reg[WIDTH-1:1]}.
  - SRA: {reg[WIDTH-1],reg[WIDTH-1:1]}.
  - ROTR: {reg[0],reg[WIDTH-1:1]}.
- FINISH (one cycle only):
  - DONE=1, BUSY=0.
  - SHIFT_OUT is updated with the working reg on the edge entering FINISH, so it is valid while DONE=1.
  - Next state is IDLE.
  - START in the FINISH cycle is ignored; the controller re-issues it in IDLE.
- Latency: START sampled on edge E0 gives DONE high in the cycle after edge E0+SHAMT.
  - SHAMT=0: DONE in the cycle immediately after acceptance. SHIFT_OUT = SHIFT_IN unchanged for all OPs.
  - SHAMT=31: 32-cycle latency.
- BUSY is high during SHIFT only. It is low in IDLE and FINISH.
- Operands and OP are captured at acceptance. Changes on the inputs during SHIFT have no effect.
- FLUSH=1 (synchronous, any state):
  - Next state is IDLE, count=0, no DONE pulse, SHIFT_OUT unchanged.
  - FLUSH takes priority over START in the same cycle; that START is dropped.
  - FLUSH in the FINISH cycle does not suppress the DONE already asserted, but SHIFT_OUT keeps the value committed on entering FINISH.
- RESET_N low mid-operation aborts immediately with all outputs at reset values. No DONE is issued after release.
- Arithmetic: SRA replicates the sign bit captured at acceptance. No overflow detection. SLL discards bits shifted past the MSB.

Test Plan:
- Reset then idle: hold RESET_N=0 for 3 cycles, release -> BUSY=0, DONE=0, SHIFT_OUT=0x00000000. No DONE over 10 idle cycles.
- SRA sign fill:
  - Stimulus: START with OP=11, SHIFT_IN=0x80000010, SHAMT=4.
  - Response: BUSY high for 4 cycles, then a single DONE with SHIFT_OUT=0xF8000001.
  - Repeat with OP=01 -> 0x08000001.
- Zero and max shift:
  - SHAMT=0, OP=10, SHIFT_IN=0x12345678 -> DONE in the cycle after acceptance with 0x12345678, BUSY never high.
  - SHAMT=31, OP=00, SHIFT_IN=0x00000001 -> DONE after 32 cycles with 0x80000000.
- ROTR wrap: SHIFT_IN=0x000000F1, SHAMT=4 -> SHIFT_OUT=0x1000000F.
- START while busy plus FLUSH:
  - Start SRL 0xFFFFFFFF with SHAMT=8.
  - Re-pulse START with different data mid-shift -> ignored, result 0x00FFFFFF.
  - Next op: assert FLUSH on cycle 3 of SHIFT -> no DONE, SHIFT_OUT stays 0x00FFFFFF.
  - A new START accepted the next cycle completes normally.
- Async reset mid-operation: drop RESET_N between clock edges during SHIFT -> outputs zero immediately. After release, no spurious DONE.
